// File: rtl/window3x3_stream_if.sv
// window3x3_stream_if: pixel input stream and 3x3 window output stream of window3x3_stream.
interface window3x3_stream_if #(parameter int PIXEL_W = 8);
    logic                 in_valid;
    logic                 in_ready;
    logic [PIXEL_W-1:0]   pixel_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [9*PIXEL_W-1:0] window;
    logic                 on_edge;
    modport master (output in_valid, pixel_in, out_ready, input in_ready, out_valid, window, on_edge);
    modport slave  (input in_valid, pixel_in, out_ready, output in_ready, out_valid, window, on_edge);
endinterface

// File: rtl/window3x3_stream.sv
// window3x3_stream: raster-order pixel stream to one 3x3 neighbourhood per pixel,
// two internal line buffers, zero-fill or edge-replicate borders chosen per frame.
module window3x3_stream #(
    parameter int PIXEL_W = 8,
    parameter int CNT_W   = 12,
    parameter int MAX_X   = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] size_x,
    input  logic [CNT_W-1:0] size_y,
    input  logic             border_mode,
    output logic             busy,
    output logic             done,
    output logic             size_err,
    window3x3_stream_if.slave strm
);
    localparam int AW = $clog2(MAX_X);
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t                       state;
    logic [CNT_W-1:0]             w, h, x, y, cx, cy;
    logic                         mode, tail, last, free, acc, ev, wrap, emit, legal;
    logic [AW-1:0]                xa;
    logic [PIXEL_W-1:0]           lb0 [MAX_X];
    logic [PIXEL_W-1:0]           lb1 [MAX_X];
    logic [2:0][PIXEL_W-1:0]      col_a, col_b, col_n;
    logic [2:0][2:0][PIXEL_W-1:0] raw;
    logic [2:0]                   rv, cv;
    logic [2:0][1:0]              rsel, csel;
    logic [9*PIXEL_W-1:0]         win_d;
    assign busy          = state != IDLE;
    assign free          = !strm.out_valid || strm.out_ready;
    assign strm.in_ready = (state == FILL || state == RUN) && free;
    assign acc           = strm.in_valid && strm.in_ready;
    // flush replays a virtual row H (bottom border) plus one tail event for the last centre
    assign ev            = acc || (state == FLUSH && !last && free);
    assign wrap          = x == '0;
    assign emit          = wrap ? (tail || y >= CNT_W'(2)) : y != '0;
    assign legal         = size_x >= CNT_W'(2) && {1'b0, size_x} <= (CNT_W+1)'(MAX_X) && size_y >= CNT_W'(2);
    assign xa            = x[AW-1:0];
    assign col_n         = {strm.pixel_in, lb1[xa], lb0[xa]};
    assign raw           = {col_n, col_b, col_a};
    assign cx            = wrap ? w - 1'b1 : x - 1'b1;
    assign cy            = tail ? h - 1'b1 : wrap ? y - 2'd2 : y - 1'b1;
    assign rv            = {cy != h - 1'b1, 1'b1, cy != '0};
    assign cv            = {cx != w - 1'b1, 1'b1, cx != '0};
    assign rsel          = {rv[2] ? 2'd2 : 2'd1, 2'd1, rv[0] ? 2'd0 : 2'd1};
    assign csel          = {cv[2] ? 2'd2 : 2'd1, 2'd1, cv[0] ? 2'd0 : 2'd1};
    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win_d[PIXEL_W*(3*r+c) +: PIXEL_W] = (mode || (rv[r] && cv[c])) ? raw[csel[c]][rsel[r]] : '0;
    end
    always_ff @(posedge clk)
        if (acc) begin
            lb1[xa] <= strm.pixel_in;
            lb0[xa] <= lb1[xa];
        end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            {w, h, x, y}   <= '0;
            {mode, tail, last} <= '0;
            col_a          <= '0;
            col_b          <= '0;
            strm.out_valid <= 1'b0;
            strm.window    <= '0;
            strm.on_edge   <= 1'b0;
            done           <= 1'b0;
            size_err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ev && emit) begin
                strm.out_valid <= 1'b1;
                strm.window    <= win_d;
                strm.on_edge   <= ~&{rv, cv};
            end else if (strm.out_ready)
                strm.out_valid <= 1'b0;
            if (ev) begin
                col_a <= col_b;
                col_b <= col_n;
                if (tail) begin
                    tail <= 1'b0;
                    last <= 1'b1;
                end else if (x == w - 1'b1) begin
                    x <= '0;
                    if (y == h) tail <= 1'b1;
                    else y <= y + 1'b1;
                end else
                    x <= x + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    if (legal) begin
                        {w, h, mode} <= {size_x, size_y, border_mode};
                        {x, y}       <= '0;
                        {tail, last} <= '0;
                        size_err     <= 1'b0;
                        state        <= FILL;
                    end else
                        size_err <= 1'b1;
                end
                FILL:  if (acc && wrap && y == CNT_W'(1)) state <= RUN;
                RUN:   if (acc && x == w - 1'b1 && y == h - 1'b1) state <= FLUSH;
                FLUSH: if (last && strm.out_valid && strm.out_ready) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window3x3_stream.sv
// tb_window3x3_stream: scoreboard bench; a direct neighbourhood model fills the
// expected queue per frame and every output handshake is popped and compared.
module tb_window3x3_stream;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, border_mode = 1'b0;
    logic [11:0] size_x = '0, size_y = '0;
    logic        busy, done, size_err;
    int          checks = 0, errors = 0;
    logic [7:0]  img [0:63];
    logic [72:0] got [0:63];
    logic [72:0] q [$];
    window3x3_stream_if #(.PIXEL_W(8)) s ();
    window3x3_stream #(.PIXEL_W(8), .CNT_W(12), .MAX_X(4096)) dut (
        .clk(clk), .rst(rst), .start(start), .size_x(size_x), .size_y(size_y),
        .border_mode(border_mode), .busy(busy), .done(done), .size_err(size_err), .strm(s)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask
    function automatic logic [72:0] model(int cx, int cy, int w, int h, bit m);
        logic [72:0] r;
        int px, py;
        bit ok;
        r = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                px = cx + dx;
                py = cy + dy;
                ok = px >= 0 && px < w && py >= 0 && py < h;
                px = px < 0 ? 0 : px >= w ? w - 1 : px;
                py = py < 0 ? 0 : py >= h ? h - 1 : py;
                if (ok || m) r[8*(3*(dy+1)+(dx+1)) +: 8] = img[py*w+px];
            end
        r[72] = cx == 0 || cx == w - 1 || cy == 0 || cy == h - 1;
        return r;
    endfunction
    task automatic fill_img(input bit rnd);
        for (int i = 0; i < 64; i++) img[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
    endtask
    task automatic do_start(input int w, input int h, input bit m);
        @(negedge clk);
        start = 1'b1; size_x = 12'(w); size_y = 12'(h); border_mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask
    // stall: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random; poke >= 0 pulses start at that input index
    task automatic run_frame(input int w, input int h, input bit m, input int stall, input bit rnd, input int poke);
        int n, idx, outs, dones, cyc;
        n = w * h;
        q.delete();
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) q.push_back(model(xx, yy, w, h, m));
        do_start(w, h, m);
        #1;
        check("busy_start", 80'(busy), 80'(1));
        check("err_start", 80'(size_err), 80'(0));
        idx = 0; outs = 0; dones = 0; cyc = 0;
        while ((outs < n || dones == 0) && cyc < 3000) begin
            @(negedge clk);
            s.out_ready = stall == 0 ? 1'b1 : stall == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            s.in_valid  = idx < n && (!rnd || $urandom_range(0, 3) != 0);
            s.pixel_in  = idx < n ? img[idx] : 8'h0;
            if (poke >= 0 && idx == poke) begin
                start = 1'b1; size_x = 12'd2; size_y = 12'd2;
            end else
                start = 1'b0;
            cyc++;
            #1;
            if (s.out_valid) begin
                if (q.size() == 0)
                    check("extra_window", 80'(1), 80'(0));
                else begin
                    check("window", {7'd0, s.on_edge, s.window}, {7'd0, q[0]});
                    if (!s.out_ready) check("stall_in_ready", 80'(s.in_ready), 80'(0));
                    else begin
                        got[outs] = {s.on_edge, s.window};
                        outs++;
                        void'(q.pop_front());
                    end
                end
            end
            if (s.in_valid && s.in_ready) idx++;
            if (done) dones++;
        end
        start = 1'b0;
        s.in_valid = 1'b0;
        s.out_ready = 1'b1;
        check("inputs", 80'(idx), 80'(n));
        check("outputs", 80'(outs), 80'(n));
        check("done_seen", 80'(dones), 80'(1));
        @(negedge clk);
        #1;
        check("done_once", 80'(done), 80'(0));
        check("idle", 80'(busy), 80'(0));
    endtask
    initial begin
        s.in_valid = 1'b0; s.pixel_in = '0; s.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 80'(s.in_ready), 80'(0));
        check("rst_out_valid", 80'(s.out_valid), 80'(0));
        check("rst_window", 80'(s.window), 80'(0));
        check("rst_on_edge", 80'(s.on_edge), 80'(0));
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_done", 80'(done), 80'(0));
        check("rst_size_err", 80'(size_err), 80'(0));
        @(negedge clk);
        rst = 1'b1;
        fill_img(1'b0);
        run_frame(4, 3, 1'b0, 0, 1'b0, -1);
        check("m0_first", 80'(got[0]), 80'({1'b1, 8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}));
        check("m0_win11", 80'(got[5]), 80'({1'b0, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}));
        run_frame(4, 3, 1'b1, 0, 1'b0, -1);
        check("m1_win00", 80'(got[0]), 80'({1'b1, 8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0}));
        check("m1_win32", 80'(got[11]), 80'({1'b1, 8'd11, 8'd11, 8'd10, 8'd11, 8'd11, 8'd10, 8'd7, 8'd7, 8'd6}));
        run_frame(4, 3, 1'b0, 1, 1'b0, -1);
        check("stall_first", 80'(got[0]), 80'({1'b1, 8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}));
        @(negedge clk);
        start = 1'b1; size_x = 12'd1; size_y = 12'd3;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("bad_size_err", 80'(size_err), 80'(1));
        check("bad_size_busy", 80'(busy), 80'(0));
        run_frame(2, 2, 1'b0, 0, 1'b0, -1);
        do_start(4, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s.in_valid = 1'b1;
            s.pixel_in = img[i];
            @(negedge clk);
        end
        s.in_valid = 1'b0;
        #2;
        check("mid_busy", 80'(busy), 80'(1));
        rst = 1'b0;
        #1;
        check("abort_outputs", {73'd0, s.in_ready, s.out_valid, s.on_edge, busy, done, size_err, |s.window}, 80'(0));
        @(negedge clk);
        rst = 1'b1;
        run_frame(4, 3, 1'b0, 0, 1'b0, -1);
        check("post_rst_first", 80'(got[0]), 80'({1'b1, 8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}));
        check("post_rst_win11", 80'(got[5]), 80'({1'b0, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}));
        run_frame(4, 3, 1'b0, 0, 1'b0, 6);
        fill_img(1'b1);
        run_frame(7, 5, 1'b1, 2, 1'b1, -1);
        run_frame(5, 4, 1'b0, 2, 1'b1, -1);
        run_frame(2, 6, 1'b1, 1, 1'b1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
